rfphoenix_dc_fill_ctrl: RTL and testbench

//  Sequencer for the data-cache tag array (rfPhoenix_dctag) and data RAM. Accepts one lookup
//  at a time, compares the four way tags, and on a miss picks a victim way, bursts the line from

---
 rtl/rfphoenix_dc_fill_ctrl_pkg.sv | 26 ++
 rtl/rfphoenix_dc_victim.sv | 17 +
 rtl/rfphoenix_dc_fill_ctrl.sv | 159 +++++++++++++++
 tb/tb_rfphoenix_dc_fill_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_dc_fill_ctrl_pkg.sv
// Shared constants and types for the data-cache fill sequencer.
package rfphoenix_dc_fill_ctrl_pkg;

   typedef logic [31:0] Address;

   localparam int unsigned DC_LINES  = 256;
   localparam int unsigned DC_WAYS   = 4;
   localparam int unsigned DC_LOBIT  = 6;
   localparam int unsigned DC_TAGBIT = 14;
   localparam int unsigned DC_BEATS  = 4;

   localparam int unsigned DC_NW    = $clog2(DC_LINES);
   localparam int unsigned DC_WW    = $clog2(DC_WAYS);
   localparam int unsigned DC_BW    = $clog2(DC_BEATS);
   localparam int unsigned DC_TAGW  = $bits(Address) - DC_TAGBIT;
   localparam int unsigned DC_LINEW = $bits(Address) - DC_LOBIT;

   typedef logic [2:0] dc_fill_state_t;

   localparam dc_fill_state_t ST_IDLE      = 3'd0;
   localparam dc_fill_state_t ST_LOOKUP    = 3'd1;
   localparam dc_fill_state_t ST_FILL_REQ  = 3'd2;
   localparam dc_fill_state_t ST_FILL_DATA = 3'd3;
   localparam dc_fill_state_t ST_TAG_UPD   = 3'd4;

endpackage

// File: rtl/rfphoenix_dc_victim.sv
// Victim way select: lowest invalid way, otherwise the round-robin pointer.
module rfphoenix_dc_victim
   import rfphoenix_dc_fill_ctrl_pkg::*;
(
   input  logic [DC_WAYS-1:0] i_valid,
   input  logic [DC_WW-1:0]   i_rr,
   output logic [DC_WW-1:0]   o_victim
);

   always_comb begin
      o_victim = i_rr;
      for (int w = DC_WAYS - 1; w >= 0; w--) begin
         if (!i_valid[w]) o_victim = DC_WW'(w);
      end
   end

endmodule

// File: rtl/rfphoenix_dc_fill_ctrl.sv
// Data-cache lookup/fill sequencer: tag compare, victim select, line burst, tag write, replay.
module rfphoenix_dc_fill_ctrl
   import rfphoenix_dc_fill_ctrl_pkg::*;
(
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_req,
   input  Address                          i_req_adr,
   output logic                            o_rdy,
   output logic                            o_done,
   output logic [DC_WW-1:0]                o_done_way,
   output logic                            o_err,
   input  logic                            i_inv_all,
   output logic [DC_NW-1:0]                o_tag_ndx,
   input  logic [DC_WAYS-1:0][DC_TAGW-1:0] i_tag_in,
   output logic                            o_tag_wr,
   output Address                          o_tag_wadr,
   output logic [DC_WW-1:0]                o_tag_way,
   output logic                            o_mem_req,
   output Address                          o_mem_adr,
   input  logic                            i_mem_ack,
   input  logic                            i_mem_rdy,
   input  logic                            i_mem_err,
   output logic                            o_dat_wr,
   output logic [DC_WW-1:0]                o_dat_way,
   output logic [DC_BW-1:0]                o_dat_beat
);

   localparam logic [DC_BW-1:0] LAST_BEAT = DC_BW'(DC_BEATS - 1);

   dc_fill_state_t                  r_state;
   logic [DC_LINEW-1:0]             r_line;
   logic [DC_WW-1:0]                r_victim;
   logic [DC_BW-1:0]                r_beat;
   logic [DC_WW-1:0]                r_rr;
   logic                            r_done;
   logic [DC_WW-1:0]                r_done_way;
   logic                            r_err;
   logic                            r_inv_pend;
   logic [DC_WAYS-1:0][DC_LINES-1:0] r_valid;

   logic                w_idle;
   logic                w_rdy;
   logic                w_take;
   logic [DC_NW-1:0]    w_ndx_q;
   logic [DC_TAGW-1:0]  w_tag_q;
   logic [DC_WAYS-1:0]  w_vld;
   logic [DC_WAYS-1:0]  w_hit;
   logic [DC_WW-1:0]    w_hit_way;
   logic [DC_WW-1:0]    w_victim;
   Address              w_line_adr;
   logic                w_unused_lo;

   assign w_unused_lo = ^i_req_adr[DC_LOBIT-1:0];

   assign w_idle     = (r_state == ST_IDLE);
   // A deferred invalidate costs one idle cycle in which no request is taken.
   assign w_rdy      = w_idle & ~r_inv_pend;
   assign w_take     = i_req & w_rdy;
   assign w_ndx_q    = r_line[DC_NW-1:0];
   assign w_tag_q    = r_line[DC_LINEW-1:DC_TAGBIT-DC_LOBIT];
   assign w_line_adr = {r_line, {DC_LOBIT{1'b0}}};

   always_comb begin
      w_hit_way = '0;
      for (int w = 0; w < DC_WAYS; w++) begin
         w_vld[w] = r_valid[w][w_ndx_q];
         w_hit[w] = w_vld[w] & (i_tag_in[w] == w_tag_q);
      end
      for (int w = DC_WAYS - 1; w >= 0; w--) begin
         if (w_hit[w]) w_hit_way = DC_WW'(w);
      end
   end

   rfphoenix_dc_victim u_victim (
      .i_valid  (w_vld),
      .i_rr     (r_rr),
      .o_victim (w_victim)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_line     <= '0;
         r_victim   <= '0;
         r_beat     <= '0;
         r_rr       <= '0;
         r_done     <= 1'b0;
         r_done_way <= '0;
         r_err      <= 1'b0;
         r_inv_pend <= 1'b0;
         r_valid    <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (i_inv_all && !w_idle) r_inv_pend <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (r_inv_pend || i_inv_all) r_valid <= '0;
               r_inv_pend <= 1'b0;
               if (w_take) begin
                  r_line  <= i_req_adr[$bits(Address)-1:DC_LOBIT];
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (|w_hit) begin
                  r_done     <= 1'b1;
                  r_done_way <= w_hit_way;
                  r_state    <= ST_IDLE;
               end else begin
                  r_victim <= w_victim;
                  r_rr     <= r_rr + 1'b1;
                  r_state  <= ST_FILL_REQ;
               end
            end
            ST_FILL_REQ: begin
               if (i_mem_err) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (i_mem_ack) begin
                  r_beat  <= '0;
                  r_state <= ST_FILL_DATA;
               end
            end
            ST_FILL_DATA: begin
               if (i_mem_err) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (i_mem_rdy) begin
                  r_beat <= r_beat + 1'b1;
                  if (r_beat == LAST_BEAT) r_state <= ST_TAG_UPD;
               end
            end
            ST_TAG_UPD: begin
               r_valid[r_victim][w_ndx_q] <= 1'b1;
               r_state                    <= ST_LOOKUP;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Index is held outside IDLE so the registered tag read stays stable.
   assign o_tag_ndx  = w_idle ? i_req_adr[DC_LOBIT +: DC_NW] : w_ndx_q;
   assign o_rdy      = w_rdy;
   assign o_done     = r_done;
   assign o_done_way = r_done_way;
   assign o_err      = r_err;
   assign o_tag_wr   = (r_state == ST_TAG_UPD);
   assign o_tag_wadr = w_line_adr;
   assign o_tag_way  = r_victim;
   assign o_mem_req  = (r_state == ST_FILL_REQ);
   assign o_mem_adr  = w_line_adr;
   assign o_dat_wr   = (r_state == ST_FILL_DATA) & i_mem_rdy;
   assign o_dat_way  = r_victim;
   assign o_dat_beat = r_beat;

endmodule

// File: tb/tb_rfphoenix_dc_fill_ctrl.sv
// Bench for rfphoenix_dc_fill_ctrl: directed and random lookups against a cache-content model.
module tb_rfphoenix_dc_fill_ctrl;
   import rfphoenix_dc_fill_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst, req, inv_all, mem_ack, mem_rdy, mem_err;
   Address req_adr;
   logic rdy, done, err, tag_wr, mem_req, dat_wr;
   logic [DC_WW-1:0] done_way, tag_way, dat_way;
   logic [DC_BW-1:0] dat_beat;
   logic [DC_NW-1:0] tag_ndx;
   logic [DC_WAYS-1:0][DC_TAGW-1:0] tag_in;
   Address tag_wadr, mem_adr;

   always #5 clk = ~clk;

   rfphoenix_dc_fill_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .i_req_adr  (req_adr),
      .o_rdy      (rdy),
      .o_done     (done),
      .o_done_way (done_way),
      .o_err      (err),
      .i_inv_all  (inv_all),
      .o_tag_ndx  (tag_ndx),
      .i_tag_in   (tag_in),
      .o_tag_wr   (tag_wr),
      .o_tag_wadr (tag_wadr),
      .o_tag_way  (tag_way),
      .o_mem_req  (mem_req),
      .o_mem_adr  (mem_adr),
      .i_mem_ack  (mem_ack),
      .i_mem_rdy  (mem_rdy),
      .i_mem_err  (mem_err),
      .o_dat_wr   (dat_wr),
      .o_dat_way  (dat_way),
      .o_dat_beat (dat_beat)
   );

   // Tag array: registered read, a same-edge write is visible to the read.
   logic [DC_TAGW-1:0] tarr [DC_WAYS][DC_LINES];
   always @(posedge clk) begin
      for (int w = 0; w < DC_WAYS; w++) begin
         tag_in[w] <= (tag_wr && int'(tag_way) == w && tag_wadr[DC_LOBIT +: DC_NW] == tag_ndx) ?
                      tag_wadr[$bits(Address)-1:DC_TAGBIT] : tarr[w][tag_ndx];
      end
      if (tag_wr) tarr[tag_way][tag_wadr[DC_LOBIT +: DC_NW]] <= tag_wadr[$bits(Address)-1:DC_TAGBIT];
   end

   localparam int M_NONE = 0, M_ERR = 1, M_RST = 2, M_INV = 3, M_INVREQ = 4;

   int errors = 0;
   int checks = 0;

   // Model of cache contents
   bit                 mv [DC_WAYS][DC_LINES];
   logic [DC_TAGW-1:0] mt [DC_WAYS][DC_LINES];
   int                 mrr;
   bit                 mpend;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_clear();
      for (int w = 0; w < DC_WAYS; w++)
         for (int l = 0; l < DC_LINES; l++) mv[w][l] = 1'b0;
   endtask

   function automatic int m_hit(input Address a);
      int ndx;
      ndx = int'(a[DC_LOBIT +: DC_NW]);
      for (int w = 0; w < DC_WAYS; w++)
         if (mv[w][ndx] && mt[w][ndx] == a[$bits(Address)-1:DC_TAGBIT]) return w;
      return -1;
   endfunction

   function automatic int m_victim(input Address a);
      int ndx;
      ndx = int'(a[DC_LOBIT +: DC_NW]);
      for (int w = 0; w < DC_WAYS; w++) if (!mv[w][ndx]) return w;
      return mrr;
   endfunction

   task automatic lookup(input Address a, input int mode, input int ab);
      int hw, vic, n, ndx;
      Address line;
      ndx  = int'(a[DC_LOBIT +: DC_NW]);
      line = a & ~32'h3F;
      n = 0;
      while (!rdy && n < 10) begin
         step();
         n++;
      end
      chk("rdy_before_req", 32'(rdy), 32'd1);
      req = 1'b1;
      req_adr = a;
      if (mode == M_INVREQ) inv_all = 1'b1;
      step();
      req = 1'b0;
      inv_all = 1'b0;
      if (mode == M_INVREQ) m_clear();
      chk("lookup_no_done", 32'(done), 32'd0);
      chk("lookup_no_memreq", 32'(mem_req), 32'd0);
      chk("lookup_not_rdy", 32'(rdy), 32'd0);
      hw = m_hit(a);
      if (hw >= 0) begin
         step();
         chk("hit_done", 32'(done), 32'd1);
         chk("hit_way", 32'(done_way), 32'(hw));
         chk("hit_no_memreq", 32'(mem_req), 32'd0);
         chk("hit_rdy", 32'(rdy), 32'd1);
         return;
      end
      vic = m_victim(a);
      mrr = (mrr + 1) % DC_WAYS;
      step();
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_adr", mem_adr, line);
      n = $urandom_range(0, 3);
      repeat (n) begin
         step();
         chk("mem_req_hold", 32'(mem_req), 32'd1);
      end
      mem_ack = 1'b1;
      mem_rdy = 1'b1;
      #1;
      chk("ack_cycle_no_datwr", 32'(dat_wr), 32'd0);
      step();
      mem_ack = 1'b0;
      mem_rdy = 1'b0;
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      for (int b = 0; b < DC_BEATS; b++) begin
         if (mode == M_INV && b == ab) begin
            inv_all = 1'b1;
            step();
            inv_all = 1'b0;
            mpend = 1'b1;
            chk("inv_gap_no_datwr", 32'(dat_wr), 32'd0);
         end
         n = $urandom_range(0, 2);
         repeat (n) begin
            step();
            chk("gap_no_datwr", 32'(dat_wr), 32'd0);
         end
         if (mode == M_ERR && b == ab) begin
            mem_err = 1'b1;
            step();
            mem_err = 1'b0;
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_no_tagwr", 32'(tag_wr), 32'd0);
            chk("err_no_done", 32'(done), 32'd0);
            chk("err_rdy", 32'(rdy), 32'd1);
            step();
            chk("err_one_cycle", 32'(err), 32'd0);
            return;
         end
         if (mode == M_RST && b == ab) begin
            rst = 1'b1;
            mem_rdy = 1'b1;
            step();
            chk("rst_memreq", 32'(mem_req), 32'd0);
            chk("rst_datwr", 32'(dat_wr), 32'd0);
            chk("rst_rdy", 32'(rdy), 32'd1);
            rst = 1'b0;
            step();
            chk("rst_beat_ignored", 32'(dat_wr), 32'd0);
            chk("rst_no_tagwr", 32'(tag_wr), 32'd0);
            mem_rdy = 1'b0;
            m_clear();
            mrr = 0;
            mpend = 1'b0;
            return;
         end
         mem_rdy = 1'b1;
         #1;
         chk("dat_wr", 32'(dat_wr), 32'd1);
         chk("dat_beat", 32'(dat_beat), 32'(b));
         chk("dat_way", 32'(dat_way), 32'(vic));
         step();
         mem_rdy = 1'b0;
      end
      chk("tag_wr", 32'(tag_wr), 32'd1);
      chk("tag_way", 32'(tag_way), 32'(vic));
      chk("tag_wadr", tag_wadr, line);
      chk("tagupd_no_datwr", 32'(dat_wr), 32'd0);
      mv[vic][ndx] = 1'b1;
      mt[vic][ndx] = a[$bits(Address)-1:DC_TAGBIT];
      step();
      chk("replay_no_done", 32'(done), 32'd0);
      chk("replay_no_tagwr", 32'(tag_wr), 32'd0);
      step();
      chk("fill_done", 32'(done), 32'd1);
      chk("fill_way", 32'(done_way), 32'(vic));
      chk("done_rdy", 32'(rdy), mpend ? 32'd0 : 32'd1);
      if (mpend) begin
         m_clear();
         mpend = 1'b0;
      end
   endtask

   initial begin
      int md, bt;
      Address a;
      rst = 1'b1;
      req = 1'b0;
      req_adr = '0;
      inv_all = 1'b0;
      mem_ack = 1'b0;
      mem_rdy = 1'b0;
      mem_err = 1'b0;
      m_clear();
      mrr = 0;
      mpend = 1'b0;
      repeat (3) step();
      chk("rst_rdy", 32'(rdy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_tag_wr", 32'(tag_wr), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_dat_wr", 32'(dat_wr), 32'd0);
      chk("rst_done_way", 32'(done_way), 32'd0);
      chk("rst_tag_way", 32'(tag_way), 32'd0);
      chk("rst_dat_way", 32'(dat_way), 32'd0);
      chk("rst_dat_beat", 32'(dat_beat), 32'd0);
      rst = 1'b0;
      step();

      lookup(32'h0001_2340, M_NONE, 0);
      lookup(32'h0001_2340, M_NONE, 0);
      for (int k = 1; k <= 4; k++) lookup(32'h0001_2340 + 32'(k) * 32'h4000, M_NONE, 0);
      lookup(32'h0001_2340 + 32'h4000, M_NONE, 0);
      lookup(32'h0003_0080, M_ERR, 2);
      lookup(32'h0003_0080, M_NONE, 0);
      lookup(32'h0003_0080, M_NONE, 0);
      lookup(32'h0005_0100, M_INV, 1);
      lookup(32'h0005_0100, M_NONE, 0);
      lookup(32'h0005_0100, M_INVREQ, 0);
      lookup(32'h0007_1000, M_RST, 1);
      lookup(32'h0005_0100, M_NONE, 0);

      for (int i = 0; i < 60; i++) begin
         a = (32'($urandom_range(0, 7)) << DC_TAGBIT) |
             (32'($urandom_range(0, 3) * 37) << DC_LOBIT) | 32'($urandom_range(0, 63));
         md = $urandom_range(0, 9);
         bt = $urandom_range(0, 3);
         case (md)
            0:       lookup(a, M_ERR, bt);
            1:       lookup(a, M_INV, bt);
            2:       lookup(a, M_INVREQ, 0);
            default: lookup(a, M_NONE, 0);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout waiting for bench to finish");
      $fatal(1, "timeout");
   end

endmodule
